charge_integrator: RTL and testbench
====================================

# charge_integrator

Measurement responder for the secant current-reference controller. It accepts a current code `i_ref`, drives it to the DAC, waits a fixed settling interval, then averages a window of ADC charge samples. It returns the result on `q_measured` with a one-cycle `ready` pulse, closing the controller's `i_ref` → `q_measured` / `ready` loop.

## Interface
- `BUS_WIDTH`, 10: width of `i_ref`, `dac_code`, `adc_sample` and `q_measured`.
- `SETTLE_CYCLES`, 16: cycles spent settling after a new DAC code is applied; 0 is legal.
- `WINDOW_LOG2`, 4: log2 of the number of samples averaged, N = 2^WINDOW_LOG2; 0 is legal.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  measurement request; sampled only in IDLE.
- `i_ref`  in  BUS_WIDTH  unsigned current code; latched on an accepted `start`.
- `adc_sample`  in  BUS_WIDTH  unsigned charge sample.
- `adc_valid`  in  1  `adc_sample` is valid this cycle.
- `dac_code`  out  BUS_WIDTH  registered DAC drive; holds the last latched `i_ref`.
- `q_measured`  out  BUS_WIDTH  registered averaged charge; holds until the next completion.
- `ready`  out  1  one-cycle pulse: `q_measured` is new.
- `busy`  out  1  high from an accepted `start` until `ready` deasserts.

## Operation
- States are IDLE, SETTLE, INTEGRATE and DONE.
- Accumulator `acc` is unsigned and BUS_WIDTH+WINDOW_LOG2 bits wide, so it cannot overflow. Sample counter is WINDOW_LOG2+1 bits. Settle counter is sized to hold SETTLE_CYCLES.
- IDLE, `start`=1:
  - `dac_code` ← `i_ref`; `acc` ← 0; sample count ← 0; `busy` ← 1.
  - Go to SETTLE, or straight to INTEGRATE when SETTLE_CYCLES=0.
- IDLE, `start`=0: hold all state.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; then go to INTEGRATE.
  - `adc_valid` is ignored.
- INTEGRATE:
  - On each edge with `adc_valid`=1: `acc` ← `acc` + `adc_sample`; count += 1.
  - On the edge that accepts the Nth sample:
    - `q_measured` ← (acc_final + 2^(WINDOW_LOG2-1)) >> WINDOW_LOG2, round-half-up. acc_final includes that Nth sample.
    - When WINDOW_LOG2=0, no rounding term: `q_measured` ← `adc_sample`.
    - Result is never above 2^BUS_WIDTH-1; no saturation logic is needed.
    - `ready` ← 1; go to DONE.
- DONE: `ready` ← 0; `busy` ← 0; go to IDLE.
- `start` in SETTLE, INTEGRATE or DONE is ignored; no queueing.
- `i_ref` changes after acceptance do not affect `dac_code`.
- `adc_valid` in IDLE or DONE is ignored.
- Reset asserted at any time:
  - `dac_code`=0, `q_measured`=0, `ready`=0, `busy`=0, `acc`=0, counters 0, state IDLE.
  - An in-flight measurement is aborted with no `ready`.
- Reset release: the first edge with `rst`=1 may accept `start`.

## Timing
- `start` accepted at edge T0:
  - `dac_code` and `busy` are valid after T0.
  - SETTLE spans edges T1…T(SETTLE_CYCLES).
- Samples are accepted from edge T(SETTLE_CYCLES+1) onward.
- With `adc_valid` continuously high, `ready` rises at edge T0+SETTLE_CYCLES+N, together with the new `q_measured`. `ready` and `busy` fall at the following edge.
- With gaps, `ready` rises at the edge accepting the Nth valid sample.
- Minimum start-to-start spacing is SETTLE_CYCLES+N+2 cycles: `start` can be re-accepted at the edge after `busy` falls.
- `ready` is never high for more than one cycle. `ready`=1 implies `busy`=1 in the same cycle.

## Test plan
All scenarios use BUS_WIDTH=10, SETTLE_CYCLES=4, WINDOW_LOG2=2 (N=4).
- Reset with `rst` low: `dac_code`=0, `q_measured`=0, `ready`=0, `busy`=0. Release, no `start`: outputs stay 0 for 20 cycles.
- `start` with `i_ref`=826 at T0, `adc_valid` continuous, samples 100/101/102/103 from T5 → `dac_code`=826 after T0; `ready` high for exactly one cycle after T8; `q_measured`=102 (406+2=408>>2); `busy` low after T9.
- `adc_valid` high only on alternate cycles from T5, samples 10/11/11/11 → `ready` after T11; `q_measured`=11 (43+2=45>>2). Valid samples asserted during SETTLE at T1–T4 are not accumulated.
- Extremes:
  - Four samples of 1023 → `q_measured`=1023.
  - Then a new run with four samples of 0 → `q_measured`=0.
  - Samples 1,0,0,0 → 0 (1+2=3>>2); samples 2,0,0,0 → 1.
- Ignored inputs: `start` with `i_ref`=5 at T2, and `i_ref` toggled during INTEGRATE → `dac_code` stays 826, exactly one `ready`. A `start` with `i_ref`=200 at the edge after `busy` falls is accepted (`dac_code`=200).
- Reset mid-run: `rst` low during INTEGRATE after 2 samples → all outputs 0 immediately and no `ready`. After release, a fresh `start` completes with the correct average, showing no residue from `acc`.

Source files
------------

// File: rtl/charge_integrator.sv
// Measurement responder: drives a latched current code to the DAC, waits a fixed settling
// interval, then returns the round-half-up average of 2^WINDOW_LOG2 ADC samples.
module charge_integrator #(
    parameter int unsigned BUS_WIDTH     = 10,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_LOG2   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [BUS_WIDTH-1:0] adc_sample,
    input  logic                 adc_valid,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
);
    localparam int unsigned AccW       = BUS_WIDTH + WINDOW_LOG2;
    localparam int unsigned CntW       = WINDOW_LOG2 + 1;
    localparam int unsigned SetW       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned NumSamples = 1 << WINDOW_LOG2;
    localparam int unsigned SettleLast = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StSettle, StIntegrate, StDone} state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] dac_q, dac_d;
    logic [BUS_WIDTH-1:0] meas_q, meas_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SetW-1:0]      set_q, set_d;

    logic [AccW-1:0]      acc_sum;
    logic [AccW-1:0]      acc_rnd;
    logic [BUS_WIDTH-1:0] avg_new;

    // Rounding term is N/2, which is zero for a single-sample window.
    assign acc_sum = acc_q + AccW'(adc_sample);
    assign acc_rnd = acc_sum + AccW'(NumSamples / 2);
    assign avg_new = BUS_WIDTH'(acc_rnd >> WINDOW_LOG2);

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        meas_d  = meas_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        set_d   = set_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dac_d   = i_ref;
                    acc_d   = '0;
                    cnt_d   = '0;
                    set_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (SETTLE_CYCLES == 0) ? StIntegrate : StSettle;
                end
            end
            StSettle: begin
                set_d = set_q + SetW'(1);
                if (set_q == SetW'(SettleLast)) begin
                    state_d = StIntegrate;
                end
            end
            StIntegrate: begin
                if (adc_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(NumSamples - 1)) begin
                        meas_d  = avg_new;
                        ready_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dac_q   <= '0;
            meas_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            meas_q  <= meas_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
        end
    end

    assign dac_code   = dac_q;
    assign q_measured = meas_q;
    assign ready      = ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_charge_integrator.sv
// Bench for charge_integrator: randomized sample streams checked against an arithmetic
// average model and timing rules derived from the settle length and window size.
module tb_charge_integrator;
    localparam int S = 4;
    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] i_ref;
    logic [9:0] adc_sample;
    logic       adc_valid;
    logic [9:0] dac_code;
    logic [9:0] q_measured;
    logic       ready;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    charge_integrator #(
        .BUS_WIDTH    (10),
        .SETTLE_CYCLES(S),
        .WINDOW_LOG2  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i_ref     (i_ref),
        .adc_sample(adc_sample),
        .adc_valid (adc_valid),
        .dac_code  (dac_code),
        .q_measured(q_measured),
        .ready     (ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-half-up mean of the window.
    function automatic int model_avg(input int s[4]);
        int sum;
        sum = 0;
        for (int i = 0; i < N; i++) sum += s[i];
        return (sum + N / 2) / N;
    endfunction

    // Runs one measurement starting just after a falling edge. Edge numbers are relative to
    // the accepting edge T0. mode: 0 continuous valid, 1 alternate cycles, 2 random gaps.
    task automatic measure(input int iref, input int s[4], input int mode, input bit disturb,
                           output int rdy_edge, output int rdy_cnt, output int q,
                           output int dac0, output int busy_fall, output bit dac_stable,
                           output int nth_edge, output bit busy_at_rdy);
        int  k;
        bit  go;
        rdy_edge    = -1;
        rdy_cnt     = 0;
        q           = -1;
        busy_fall   = -1;
        dac_stable  = 1'b1;
        nth_edge    = -1;
        busy_at_rdy = 1'b1;
        k           = 0;
        start       = 1'b1;
        i_ref       = 10'(iref);
        adc_valid   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dac0  = int'(dac_code);
        for (int e = 1; e <= 60; e++) begin
            adc_sample = 10'($urandom_range(0, 1023));
            adc_valid  = 1'b0;
            if (e <= S) begin
                adc_valid = 1'($urandom_range(0, 1));
            end else if (k < N) begin
                go = (mode == 0) || (mode == 1 && ((e - S - 1) % 2 == 0)) ||
                     (mode == 2 && $urandom_range(0, 1) == 1);
                if (go) begin
                    adc_valid  = 1'b1;
                    adc_sample = 10'(s[k]);
                    k++;
                    if (k == N) nth_edge = e;
                end
            end else begin
                adc_valid = 1'($urandom_range(0, 1));
            end
            if (disturb) begin
                start = (e == 2);
                i_ref = (e == 2) ? 10'd5 : 10'($urandom_range(0, 1023));
            end
            @(posedge clk);
            @(negedge clk);
            if (ready) begin
                rdy_cnt++;
                rdy_edge = e;
                q        = int'(q_measured);
                if (!busy) busy_at_rdy = 1'b0;
            end
            if (int'(dac_code) != dac0) dac_stable = 1'b0;
            if (!busy) begin
                busy_fall = e;
                break;
            end
        end
        start     = 1'b0;
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start      = 1'b1;
        i_ref      = 10'd777;
        adc_valid  = 1'b1;
        adc_sample = 10'd999;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dac_code, q_measured, ready, busy} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got dac=%0d q=%0d rdy=%0b busy=%0b, want all 0",
                     dac_code, q_measured, ready, busy);
        end
        rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            adc_valid  = 1'($urandom_range(0, 1));
            adc_sample = 10'($urandom_range(0, 1023));
            @(negedge clk);
            n_cmp++;
            if ({dac_code, q_measured, ready, busy} !== 22'd0) begin
                n_err++;
                $display("FAIL idle_after_reset cycle %0d: got dac=%0d q=%0d rdy=%0b busy=%0b, want 0",
                         c, dac_code, q_measured, ready, busy);
            end
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_basic();
        int s[4];
        int re, rc, q, d0, bf, ne;
        bit ds, br;
        s = '{100, 101, 102, 103};
        measure(826, s, 0, 1'b0, re, rc, q, d0, bf, ds, ne, br);
        n_cmp++;
        if (d0 != 826) begin n_err++; $display("FAIL basic_dac: got %0d want 826", d0); end
        n_cmp++;
        if (re != S + N) begin n_err++; $display("FAIL basic_ready_edge: got %0d want %0d", re, S + N); end
        n_cmp++;
        if (rc != 1) begin n_err++; $display("FAIL basic_ready_count: got %0d want 1", rc); end
        n_cmp++;
        if (q != 102) begin n_err++; $display("FAIL basic_q: got %0d want 102", q); end
        n_cmp++;
        if (bf != S + N + 1) begin n_err++; $display("FAIL basic_busy_fall: got %0d want %0d", bf, S + N + 1); end
        n_cmp++;
        if (!br) begin n_err++; $display("FAIL basic_busy_with_ready: got 0 want 1"); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q_measured !== 10'd102 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: got q=%0d rdy=%0b want q=102 rdy=0", q_measured, ready);
        end
    endtask

    task automatic test_gaps();
        int s[4];
        int re, rc, q, d0, bf, ne;
        bit ds, br;
        s = '{10, 11, 11, 11};
        measure(int'($urandom_range(0, 1023)), s, 1, 1'b0, re, rc, q, d0, bf, ds, ne, br);
        n_cmp++;
        if (re != 11) begin n_err++; $display("FAIL gaps_ready_edge: got %0d want 11", re); end
        n_cmp++;
        if (q != 11) begin n_err++; $display("FAIL gaps_q: got %0d want 11", q); end
        n_cmp++;
        if (rc != 1) begin n_err++; $display("FAIL gaps_ready_count: got %0d want 1", rc); end
    endtask

    task automatic test_extremes();
        int s[4];
        int want[4];
        int re, rc, q, d0, bf, ne;
        bit ds, br;
        want = '{1023, 0, 0, 1};
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: s = '{1023, 1023, 1023, 1023};
                1: s = '{0, 0, 0, 0};
                2: s = '{1, 0, 0, 0};
                default: s = '{2, 0, 0, 0};
            endcase
            @(negedge clk);
            measure(int'($urandom_range(0, 1023)), s, 0, 1'b0, re, rc, q, d0, bf, ds, ne, br);
            n_cmp++;
            if (q != want[t] || rc != 1) begin
                n_err++;
                $display("FAIL extreme_%0d: got q=%0d readies=%0d want q=%0d readies=1",
                         t, q, rc, want[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s[4];
        int re, rc, q, d0, bf, ne;
        bit ds, br;
        @(negedge clk);
        for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 1023));
        measure(826, s, 0, 1'b1, re, rc, q, d0, bf, ds, ne, br);
        n_cmp++;
        if (d0 != 826 || !ds) begin
            n_err++;
            $display("FAIL ignored_dac: got dac0=%0d stable=%0b want 826 stable=1", d0, ds);
        end
        n_cmp++;
        if (rc != 1 || q != model_avg(s)) begin
            n_err++;
            $display("FAIL ignored_result: got q=%0d readies=%0d want q=%0d readies=1",
                     q, rc, model_avg(s));
        end
        // Start again on the edge right after busy falls.
        for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 1023));
        measure(200, s, 0, 1'b0, re, rc, q, d0, bf, ds, ne, br);
        n_cmp++;
        if (d0 != 200) begin n_err++; $display("FAIL b2b_dac: got %0d want 200", d0); end
        n_cmp++;
        if (re != S + N || q != model_avg(s)) begin
            n_err++;
            $display("FAIL b2b_result: got edge=%0d q=%0d want edge=%0d q=%0d",
                     re, q, S + N, model_avg(s));
        end
    endtask

    task automatic test_reset_mid();
        int s[4];
        int re, rc, q, d0, bf, ne;
        bit ds, br;
        @(negedge clk);
        start = 1'b1;
        i_ref = 10'd300;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= S + 2; e++) begin
            adc_valid  = (e > S);
            adc_sample = 10'(900 + e);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({dac_code, q_measured, ready, busy} !== 22'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got dac=%0d q=%0d rdy=%0b busy=%0b, want all 0",
                     dac_code, q_measured, ready, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_hold cycle %0d: got rdy=%0b busy=%0b want 0", c, ready, busy);
            end
        end
        rst       = 1'b1;
        adc_valid = 1'b0;
        s = '{7, 8, 9, 1000};
        measure(123, s, 0, 1'b0, re, rc, q, d0, bf, ds, ne, br);
        n_cmp++;
        if (q != model_avg(s) || re != S + N || d0 != 123) begin
            n_err++;
            $display("FAIL midreset_rerun: got q=%0d edge=%0d dac=%0d want q=%0d edge=%0d dac=123",
                     q, re, d0, model_avg(s), S + N);
        end
    endtask

    task automatic test_random();
        int s[4];
        int re, rc, q, d0, bf, ne, iref, mode;
        bit ds, br;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 1023));
            iref = int'($urandom_range(0, 1023));
            mode = int'($urandom_range(0, 2));
            @(negedge clk);
            measure(iref, s, mode, 1'b0, re, rc, q, d0, bf, ds, ne, br);
            n_cmp++;
            if (q != model_avg(s) || rc != 1 || re != ne || bf != ne + 1 || d0 != iref || !br) begin
                n_err++;
                $display("FAIL random_%0d: got q=%0d rdy=%0d@%0d busyfall=%0d dac=%0d want q=%0d rdy=1@%0d busyfall=%0d dac=%0d",
                         t, q, rc, re, bf, d0, model_avg(s), ne, ne + 1, iref);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        i_ref      = '0;
        adc_sample = '0;
        adc_valid  = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
